bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Round-robin arbiter that shares one port of the dual-port BRAM cache among up to `NREQ` requesters, such as the CPU data path, DMA and the video fetcher. Each requester uses a req/gnt handshake with per-byte write enables. The block registers the winning access onto the BRAM port and returns read data to the winner with a tagged `rvalid` pulse. It sits between the requesters and one `clock_a`/`clock_b` side of the cache; the BRAM's other port is untouched.

## Interface
Parameters:
- `NREQ`, 3: number of requesters (2..8).
- `DW`, 32: data width; must equal BRAM `width_a`.
- `AW`, 10: address width; must equal BRAM `widthad_a`.
- `NBE`, 4: byte enables per word (`DW/8`).

Ports:
- `clock` in 1: single clock, same clock as the BRAM port it drives.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in NREQ: access request; held with stable payload until `gnt`.
- `lock` in NREQ: burst hold; owner keeps priority while high.
- `we` in NREQ: 1 = write, 0 = read.
- `addr` in NREQ*AW: flattened; slice i belongs to requester i.
- `wdata` in NREQ*DW: flattened write data.
- `be` in NREQ*NBE: flattened byte enables; ignored for reads.
- `gnt` out NREQ: one-hot, combinational; request accepted this cycle.
- `rvalid` out NREQ: one-hot pulse; `rdata` valid for that requester.
- `rdata` out DW: shared read-data bus.
- `bram_wren` out NBE: registered; to BRAM `wren`.
- `bram_address` out AW: registered.
- `bram_data` out DW: registered.
- `bram_q` in DW: BRAM `q` of the same port.

## Operation
- Arbitration is purely combinational from `req`, `lock`, `ptr` and `owner`; there is no FSM.
- `ptr` is a log2(NREQ)-bit round-robin pointer, with `ptr` = highest priority.
  - Winner = first i with `req[i]`, scanning `ptr`, `ptr+1`, … modulo NREQ.
- `gnt[winner]`=1 in the same cycle. At most one `gnt` bit per cycle; `gnt`=0 when no `req`.
- On grant to i:
  - `ptr` ← (i+1) mod NREQ, unless `lock[i]`=1, in which case `ptr` ← i.
  - `owner` ← i.
- Lock hold: while `lock[owner]`=1 and `req[owner]`=1, owner wins regardless of `ptr`.
  - Lock released or owner idle → normal rotation resumes from `ptr`.
- Granted write:
  - `bram_wren` ← `be[i]`. A write with `be`=0 is issued as a no-op; it is granted but changes nothing.
  - `bram_address` ← `addr[i]`, `bram_data` ← `wdata[i]`.
  - No `rvalid` is produced.
- Granted read:
  - `bram_wren` ← 0, `bram_address` ← `addr[i]`.
  - A 2-deep tag pipeline {valid, id} carries i to `rvalid`.
- `rdata` = `bram_q`, unregistered pass-through. It is only meaningful when some `rvalid` bit is high.
- Idle cycle: `bram_wren` ← 0; address and data hold their last value.
- Same-address write then read from different requesters in consecutive grants: the read returns the new data, because BRAM port order is preserved.

## Timing
- Grant in cycle T → BRAM inputs registered at the end of T → BRAM samples at the end of T+1 → `rvalid`/`rdata` in T+2.
  - Fixed read latency is 2 cycles after `gnt`.
- Throughput is one access per cycle, with back-to-back grants permitted.
- Read-data ordering equals grant order; `rvalid` is never stalled.
- Requester may change its payload in the cycle after `gnt`, or drop `req`.
- Dropping `req` before `gnt` is legal; nothing is issued.
- Reset (async assert) drives all of the following to 0, and release is synchronous to `clock`:
  - `ptr`, `owner`, tag pipeline.
  - `bram_wren`, `bram_address`, `bram_data`.
  - `rvalid`.
- Reset mid-read: in-flight tags are discarded and no `rvalid` follows.
- `gnt` is 0 during reset.
- `ptr` wrap: from NREQ-1 it goes to 0.

## Structure
- Package `bram_arb_pkg` holds:
  - `NREQ_MAX` = 8.
  - Typedef `req_id_t` (logic [2:0]).
  - Typedef `rd_tag_t` (struct {valid, id}).
- Sub-module `rr_pick`: a combinational rotating priority encoder.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `win`, `win_id`, `any`.
- Lock override is applied in the parent.

## Test plan
- Reads, single requester: req0 reads addr 0x010 (mem=0xDEADBEEF) → `gnt[0]` in T, `rvalid[0]` in T+2, `rdata`=0xDEADBEEF.
- Round-robin fairness: all three `req` held high for 6 cycles, `lock`=0 → grant order 0,1,2,0,1,2; exactly one `gnt` bit per cycle.
- Lock hold: req0 `lock`=1 for 4 accesses while req1/req2 are pending → four consecutive `gnt[0]`. `lock` drops → `gnt[1]`, then `gnt[2]`.
- Byte-enable write: req1 writes 0x11223344 with `be`=0b0101 to addr 5 (old 0xAABBCCDD) → later read returns 0xAA22CC44. A write with `be`=0 leaves the word unchanged.
- Write-then-read hazard: req2 writes 0x55 to addr 7 in T, req0 reads addr 7 in T+1 → `rvalid[0]` in T+3 with 0x55.
- Reset mid-flight: assert `reset_n`=0 one cycle after a read `gnt` → no `rvalid` ever appears. After release the first grant goes to req0 (`ptr`=0), and `bram_wren`=0 throughout reset.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM port arbiter: requester ids and the read-return tag.
package bram_arb_pkg;

    localparam int NREQ_MAX = 8;

    typedef logic [2:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first asserted request scanning from ptr upward, modulo NREQ.
module rr_pick
    import bram_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output req_id_t         win_id,
    output logic            any
);

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    int                pos;

    // Rotating the doubled vector puts requester ptr at bit 0.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[NREQ-1:0];

    always_comb begin
        any    = 1'b0;
        win_id = '0;
        win    = '0;
        pos    = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req_rot[i]) begin
                any = 1'b1;
                pos = int'(ptr) + i;
                if (pos >= NREQ) begin
                    pos = pos - NREQ;
                end
                win_id = req_id_t'(pos);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            win[j] = any && (int'(win_id) == j);
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter with lock hold sharing one BRAM port; registers the winning access
// and returns read data two cycles after grant with a one-hot rvalid.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 10,
    parameter int NBE  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ*AW-1:0]  addr,
    input  logic [NREQ*DW-1:0]  wdata,
    input  logic [NREQ*NBE-1:0] be,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [DW-1:0]     rdata,
    output logic [NBE-1:0]    bram_wren,
    output logic [AW-1:0]     bram_address,
    output logic [DW-1:0]     bram_data,
    input  logic [DW-1:0]     bram_q
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]  ptr_q, ptr_d;
    req_id_t        owner_q, owner_d;
    logic [NBE-1:0] bram_wren_q, bram_wren_d;
    logic [AW-1:0]  bram_address_q, bram_address_d;
    logic [DW-1:0]  bram_data_q, bram_data_d;
    rd_tag_t        tag_p0_q, tag_p0_d;
    rd_tag_t        tag_p1_q, tag_p1_d;

    logic [NREQ-1:0] pick_win;
    req_id_t         pick_id;
    logic            pick_any;

    logic            lock_hold;
    logic            grant_any;
    req_id_t         grant_id;
    logic            sel_we;
    logic            sel_lock;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [NBE-1:0]  sel_be;
    int              nxt;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .win    (pick_win),
        .win_id (pick_id),
        .any    (pick_any)
    );

    // Lock override: a locked owner that is still requesting beats the rotation.
    always_comb begin
        lock_hold = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (int'(owner_q) == j) begin
                lock_hold = lock[j] & req[j];
            end
        end
        grant_any = reset_n & (lock_hold | pick_any);
        grant_id  = lock_hold ? owner_q : pick_id;

        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        gnt       = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (int'(grant_id) == j) begin
                sel_we    = we[j];
                sel_lock  = lock[j];
                sel_addr  = addr[j*AW +: AW];
                sel_wdata = wdata[j*DW +: DW];
                sel_be    = be[j*NBE +: NBE];
                gnt[j]    = grant_any;
            end
        end
    end

    always_comb begin
        ptr_d          = ptr_q;
        owner_d        = owner_q;
        bram_wren_d    = '0;
        bram_address_d = bram_address_q;
        bram_data_d    = bram_data_q;
        tag_p0_d       = '0;
        tag_p1_d       = tag_p0_q;
        nxt            = int'(grant_id) + 1;
        if (nxt >= NREQ) begin
            nxt = 0;
        end
        if (grant_any) begin
            owner_d        = grant_id;
            ptr_d          = sel_lock ? PW'(grant_id) : PW'(nxt);
            bram_address_d = sel_addr;
            if (sel_we) begin
                bram_wren_d = sel_be;
                bram_data_d = sel_wdata;
            end else begin
                tag_p0_d.valid = 1'b1;
                tag_p0_d.id    = grant_id;
            end
        end
    end

    // Stage boundary: BRAM inputs and first tag stage at end of grant cycle; second tag
    // stage lines up with the BRAM's own sampling cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q          <= '0;
            owner_q        <= '0;
            bram_wren_q    <= '0;
            bram_address_q <= '0;
            bram_data_q    <= '0;
            tag_p0_q       <= '0;
            tag_p1_q       <= '0;
        end else begin
            ptr_q          <= ptr_d;
            owner_q        <= owner_d;
            bram_wren_q    <= bram_wren_d;
            bram_address_q <= bram_address_d;
            bram_data_q    <= bram_data_d;
            tag_p0_q       <= tag_p0_d;
            tag_p1_q       <= tag_p1_d;
        end
    end

    always_comb begin
        rvalid = '0;
        for (int j = 0; j < NREQ; j++) begin
            rvalid[j] = tag_p1_q.valid && (int'(tag_p1_q.id) == j);
        end
    end

    assign rdata        = bram_q;
    assign bram_wren    = bram_wren_q;
    assign bram_address = bram_address_q;
    assign bram_data    = bram_data_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: table-driven grant checks with a read-return scoreboard
// against a behavioural BRAM port model.
module tb_bram_port_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int NBE  = 4;

    logic              clock;
    logic              reset_n;
    logic [NREQ-1:0]   req, lock, we;
    logic [NREQ*AW-1:0]  addr;
    logic [NREQ*DW-1:0]  wdata;
    logic [NREQ*NBE-1:0] be;
    logic [NREQ-1:0]   gnt, rvalid;
    logic [DW-1:0]     rdata;
    logic [NBE-1:0]    bram_wren;
    logic [AW-1:0]     bram_address;
    logic [DW-1:0]     bram_data;
    logic [DW-1:0]     bram_q;

    bram_port_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .NBE(NBE)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req          (req),
        .lock         (lock),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .be           (be),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .bram_wren    (bram_wren),
        .bram_address (bram_address),
        .bram_data    (bram_data),
        .bram_q       (bram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // BRAM port: registered inputs are sampled here, q is valid the following cycle.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clock) begin
        for (int b = 0; b < NBE; b++) begin
            if (bram_wren[b]) mem[bram_address][b*8 +: 8] <= bram_data[b*8 +: 8];
        end
        bram_q <= mem[bram_address];
    end

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  lock;
        logic [2:0]  we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [2:0]  exp_gnt;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    sb_t  e;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mkv(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w,
                                 input logic [9:0] a, input logic [31:0] d, input logic [3:0] b,
                                 input logic [2:0] g, input logic [31:0] rd);
        vec_t v;
        v.req = r; v.lock = l; v.we = w; v.addr = a; v.wdata = d; v.be = b;
        v.exp_gnt = g; v.exp_rd = rd;
        return v;
    endfunction

    task automatic apply(input vec_t v, input bit push);
        int id;
        req   = v.req;
        lock  = v.lock;
        we    = v.we;
        addr  = {NREQ{v.addr}};
        wdata = {NREQ{v.wdata}};
        be    = {NREQ{v.be}};
        id = 0;
        for (int i = 0; i < NREQ; i++) if (v.exp_gnt[i]) id = i;
        if (push && v.exp_gnt != 0 && (v.exp_gnt & v.we) == 0)
            sb.push_back('{id: id, data: v.exp_rd, due: cyc + 2});
        @(negedge clock);
        chk("gnt", {29'd0, gnt}, {29'd0, v.exp_gnt});
        @(posedge clock);
        #1;
    endtask

    // Read-return checker: order, id, data and the fixed two-cycle latency.
    always @(negedge clock) begin
        if (rvalid !== '0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rvalid_unexpected: got rvalid=%b want none (cycle %0d)", rvalid, cyc);
            end else begin
                e = sb.pop_front();
                chk("rvalid_id", {29'd0, rvalid}, 32'(1) << e.id);
                chk("rdata", rdata, e.data);
                chk("rd_latency", cyc, e.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL rvalid_missing: got none want id %0d at cycle %0d", e.id, e.due);
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h5A00_0000 | i;
        mem[10'h010] = 32'hDEAD_BEEF;
        mem[10'h005] = 32'hAABB_CCDD;
        mem[10'h007] = 32'h0000_0000;

        reset_n = 1'b0;
        req = 3'b111; lock = '0; we = '0; addr = '0; wdata = '0; be = '0;
        repeat (2) @(negedge clock);
        chk("rst_gnt", {29'd0, gnt}, 32'd0);
        chk("rst_wren", {28'd0, bram_wren}, 32'd0);
        chk("rst_addr", {22'd0, bram_address}, 32'd0);
        chk("rst_data", bram_data, 32'd0);
        chk("rst_rvalid", {29'd0, rvalid}, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        req = '0;

        //                 req     lock    we      addr    wdata  be   gnt     rdata
        vecs.push_back(mkv(3'b001, 3'b000, 3'b000, 10'h010, 0, 4'h0, 3'b001, 32'hDEADBEEF));
        vecs.push_back(mkv(3'b000, 3'b000, 3'b000, 10'h010, 0, 4'h0, 3'b000, 0));
        vecs.push_back(mkv(3'b000, 3'b000, 3'b000, 10'h010, 0, 4'h0, 3'b000, 0));
        vecs.push_back(mkv(3'b100, 3'b000, 3'b000, 10'h010, 0, 4'h0, 3'b100, 32'hDEADBEEF));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mkv(3'b111, 3'b000, 3'b000, 10'h010, 0, 4'h0, 3'(1 << (k % 3)), 32'hDEADBEEF));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mkv(3'b111, 3'b001, 3'b000, 10'h010, 0, 4'h0, 3'b001, 32'hDEADBEEF));
        vecs.push_back(mkv(3'b110, 3'b000, 3'b000, 10'h010, 0, 4'h0, 3'b010, 32'hDEADBEEF));
        vecs.push_back(mkv(3'b100, 3'b000, 3'b000, 10'h010, 0, 4'h0, 3'b100, 32'hDEADBEEF));
        foreach (vecs[i]) apply(vecs[i], 1'b1);

        // Byte-enable write, then a be=0 write that must not disturb the word.
        apply(mkv(3'b010, 3'b000, 3'b010, 10'h005, 32'h11223344, 4'b0101, 3'b010, 0), 1'b1);
        req = '0;
        @(negedge clock);
        chk("be_wren", {28'd0, bram_wren}, 32'h5);
        chk("be_addr", {22'd0, bram_address}, 32'h5);
        chk("be_data", bram_data, 32'h11223344);
        @(posedge clock);
        #1;
        apply(mkv(3'b010, 3'b000, 3'b010, 10'h005, 32'hFFFFFFFF, 4'b0000, 3'b010, 0), 1'b1);
        req = '0;
        @(negedge clock);
        chk("be0_wren", {28'd0, bram_wren}, 32'h0);
        @(posedge clock);
        #1;
        apply(mkv(3'b010, 3'b000, 3'b000, 10'h005, 0, 4'h0, 3'b010, 32'hAA22CC44), 1'b1);

        // Write by req2 immediately followed by a read of the same word by req0.
        apply(mkv(3'b100, 3'b000, 3'b100, 10'h007, 32'h00000055, 4'hF, 3'b100, 0), 1'b1);
        apply(mkv(3'b001, 3'b000, 3'b000, 10'h007, 0, 4'h0, 3'b001, 32'h00000055), 1'b1);
        repeat (3) apply(mkv(3'b000, 3'b000, 3'b000, 10'h000, 0, 4'h0, 3'b000, 0), 1'b1);

        // Reset one cycle after a read grant: the in-flight read must vanish.
        apply(mkv(3'b010, 3'b000, 3'b000, 10'h010, 0, 4'h0, 3'b010, 0), 1'b0);
        reset_n = 1'b0;
        req = 3'b111;
        lock = '0;
        we = '0;
        repeat (3) begin
            @(negedge clock);
            chk("midrst_gnt", {29'd0, gnt}, 32'd0);
            chk("midrst_wren", {28'd0, bram_wren}, 32'd0);
            chk("midrst_rvalid", {29'd0, rvalid}, 32'd0);
            @(posedge clock);
            #1;
        end
        reset_n = 1'b1;
        apply(mkv(3'b111, 3'b000, 3'b000, 10'h010, 0, 4'h0, 3'b001, 32'hDEADBEEF), 1'b1);
        repeat (5) apply(mkv(3'b000, 3'b000, 3'b000, 10'h000, 0, 4'h0, 3'b000, 0), 1'b1);
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
